// File: rtl/pulse_capture_ctrl.sv
// Pulse capture controller: circular pre-trigger history, N-frame threshold trigger, fixed post window, oldest-first readout.
// Latency: first out_valid 2 cycles after the last post-trigger write (RAM read 1 + prefetch 1); 1 word/cycle sustained.
// Backpressure: out_valid/out_ready; word held stable while stalled; frames arriving during readout/DONE are dropped and counted.
//
// Ports:
//   clk, rst           capture clock, asynchronous active-low reset
//   frame_valid/data   one frame per cycle, channel k at [k*SAMPLE_W +: SAMPLE_W]
//   ch_mask, threshold trigger eligibility per channel, unsigned magnitude threshold
//   arm                re-arms from DONE
//   out_valid/ready    readout handshake carrying out_data, out_ch, out_last
//   state_o, drop_cnt  FSM state (FILL=0 POST=1 READ=2 DONE=3 HDR=4), saturating dropped-frame count
// Optional build macro TRIG_TIMESTAMP_EN: 32-bit frame counter latched on the trigger frame,
// emitted as two header words (high half first) ahead of the window.
module pulse_capture_ctrl #(
    parameter int SAMPLE_W   = 16,
    parameter int NUM_CH     = 4,
    parameter int DEPTH      = 256,
    parameter int PRE_LEN    = 64,
    parameter int POST_LEN   = 128,
    parameter int TRIG_COUNT = 20,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       frame_valid,
    input  logic [NUM_CH*SAMPLE_W-1:0] frame_data,
    input  logic [NUM_CH-1:0]          ch_mask,
    input  logic [SAMPLE_W-2:0]        threshold,
    input  logic                       arm,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SAMPLE_W-1:0]        out_data,
    output logic [CH_W-1:0]            out_ch,
    output logic                       out_last,
    output logic [2:0]                 state_o,
    output logic [15:0]                drop_cnt
);

    localparam int AW      = $clog2(DEPTH);
    localparam int FRAME_W = NUM_CH * SAMPLE_W;
    localparam int FILL_W  = $clog2(PRE_LEN + 1);
    localparam int POST_W  = $clog2(POST_LEN + 1);
    localparam int LEN_W   = $clog2(DEPTH + 1);
    localparam logic [7:0]      TRIG_C  = 8'(TRIG_COUNT);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    typedef enum logic [2:0] {
        ST_FILL = 3'd0,
        ST_POST = 3'd1,
        ST_READ = 3'd2,
        ST_DONE = 3'd3,
        ST_HDR  = 3'd4
    } state_t;

`ifdef TRIG_TIMESTAMP_EN
    localparam state_t RD_ENTRY = ST_HDR;
`else
    localparam state_t RD_ENTRY = ST_READ;
`endif

    state_t             state, state_nxt;
    logic [FRAME_W-1:0] mem [DEPTH];
    logic [FRAME_W-1:0] mem_q;
    logic [FRAME_W-1:0] frame_reg;
    logic [AW-1:0]      wr_ptr, rd_addr;
    logic [FILL_W-1:0]  fill_cnt;
    logic [POST_W-1:0]  post_cnt;
    logic [LEN_W-1:0]   fetch_left;
    logic [7:0]         run_cnt, run_nxt;
    logic [CH_W-1:0]    ch_idx;
    logic hot, trig, capturing, readout, wr_en, rd_en;
    logic pf_vld, pf_last, ov, ov_last, out_load, word_xfer, final_word;

`ifdef TRIG_TIMESTAMP_EN
    logic [31:0] ts_cnt, trig_ts;
    logic        hdr_idx;
`endif

    // |x| with the most negative code clamped to the largest positive magnitude.
    function automatic logic [SAMPLE_W-2:0] mag_of(input logic [SAMPLE_W-1:0] x);
        logic [SAMPLE_W-1:0] neg;
        neg = -x;
        if (!x[SAMPLE_W-1])
            return x[SAMPLE_W-2:0];
        else if (neg[SAMPLE_W-1])   // only -2^(W-1) is still negative after negation
            return '1;
        else
            return neg[SAMPLE_W-2:0];
    endfunction

    always_comb begin
        hot = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_mask[k] && (mag_of(frame_data[k*SAMPLE_W +: SAMPLE_W]) >= threshold))
                hot = 1'b1;
        end
    end

    assign run_nxt   = hot ? ((run_cnt == 8'hFF) ? run_cnt : run_cnt + 8'd1) : 8'd0;
    assign capturing = (state == ST_FILL) || (state == ST_POST);
    assign readout   = (state == ST_HDR) || (state == ST_READ);
    assign trig      = (state == ST_FILL) && frame_valid && hot && (run_nxt == TRIG_C);
    assign wr_en     = frame_valid && capturing;

    // Readout pipeline: mem_q is the prefetch slot, frame_reg the output stage.
    // The next frame moves in on the same cycle the last channel of the current one leaves.
    assign final_word = ov && ov_last && (ch_idx == LAST_CH);
    assign word_xfer  = (state == ST_READ) && ov && out_ready;
    assign out_load   = readout && pf_vld && (!ov || (word_xfer && (ch_idx == LAST_CH)));
    assign rd_en      = readout && (fetch_left != '0) && (!pf_vld || out_load);
    assign state_o    = state;

    always_comb begin
        state_nxt = state;
        out_valid = 1'b0;
        out_data  = frame_reg[int'(ch_idx)*SAMPLE_W +: SAMPLE_W];
        out_ch    = ch_idx;
        out_last  = 1'b0;
        case (state)
            ST_FILL: if (trig) state_nxt = (POST_LEN == 1) ? RD_ENTRY : ST_POST;
            ST_POST: if (frame_valid && (post_cnt == POST_W'(POST_LEN - 1))) state_nxt = RD_ENTRY;
            ST_HDR: begin
`ifdef TRIG_TIMESTAMP_EN
                out_valid = 1'b1;
                out_data  = hdr_idx ? SAMPLE_W'(trig_ts[15:0]) : SAMPLE_W'(trig_ts[31:16]);
                out_ch    = '0;
                if (out_ready && hdr_idx) state_nxt = ST_READ;
`else
                state_nxt = ST_FILL;
`endif
            end
            ST_READ: begin
                out_valid = ov;
                out_last  = final_word;
                if (ov && out_ready && final_word) state_nxt = ST_DONE;
            end
            ST_DONE: if (arm) state_nxt = ST_FILL;
            default: state_nxt = ST_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_FILL;
            wr_ptr     <= '0;
            rd_addr    <= '0;
            fill_cnt   <= '0;
            post_cnt   <= '0;
            fetch_left <= '0;
            run_cnt    <= '0;
            pf_vld     <= 1'b0;
            pf_last    <= 1'b0;
            ov         <= 1'b0;
            ov_last    <= 1'b0;
            ch_idx     <= '0;
            frame_reg  <= '0;
            drop_cnt   <= '0;
        end else begin
            state <= state_nxt;

            if (wr_en) wr_ptr <= wr_ptr + AW'(1);

            if ((state == ST_DONE) && arm)
                run_cnt <= '0;
            else if (frame_valid)
                run_cnt <= run_nxt;

            if ((state == ST_DONE) && arm)
                fill_cnt <= '0;
            else if ((state == ST_FILL) && frame_valid && !trig && (fill_cnt != FILL_W'(PRE_LEN)))
                fill_cnt <= fill_cnt + FILL_W'(1);

            // Window start counts back from the trigger slot by the frames already
            // held, so a short history simply yields a shorter window.
            if (trig) begin
                post_cnt   <= POST_W'(1);
                rd_addr    <= wr_ptr - AW'(fill_cnt);
                fetch_left <= LEN_W'(fill_cnt) + LEN_W'(POST_LEN);
            end else if ((state == ST_POST) && frame_valid) begin
                post_cnt <= post_cnt + POST_W'(1);
            end

            if (rd_en) begin
                rd_addr    <= rd_addr + AW'(1);
                fetch_left <= fetch_left - LEN_W'(1);
                pf_vld     <= 1'b1;
                pf_last    <= (fetch_left == LEN_W'(1));
            end else if (out_load) begin
                pf_vld <= 1'b0;
            end

            if (out_load) begin
                frame_reg <= mem_q;
                ch_idx    <= '0;
                ov        <= 1'b1;
                ov_last   <= pf_last;
            end else if (word_xfer) begin
                if (ch_idx == LAST_CH)
                    ov <= 1'b0;
                else
                    ch_idx <= ch_idx + CH_W'(1);
            end

            if (frame_valid && !capturing && (drop_cnt != 16'hFFFF))
                drop_cnt <= drop_cnt + 16'd1;
        end
    end

`ifdef TRIG_TIMESTAMP_EN
    // Latched value is the 0-based index of the trigger frame since reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_cnt  <= '0;
            trig_ts <= '0;
            hdr_idx <= 1'b0;
        end else begin
            if (frame_valid) ts_cnt <= ts_cnt + 32'd1;
            if (trig) trig_ts <= ts_cnt;
            if ((state == ST_HDR) && out_ready) hdr_idx <= ~hdr_idx;
        end
    end
`endif

    // Frame store: written only while capturing, read only during readout.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= frame_data;
        if (rd_en) mem_q <= mem[rd_addr];
    end

endmodule
